ppu_fb_writer: RTL and testbench
================================

PPU_FB_WRITER -- requirements
Module: ppu_fb_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, packed-byte FIFO entries (power of 2, 4..64).
REQ-002 SHALL have parameter FB_BASE, default 13'h0000, framebuffer byte base address.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port PX_OUT  input  2  pixel colour index from PPU.
REQ-006 SHALL have port PX_valid  input  1  PX_OUT valid this cycle.
REQ-007 SHALL have port PPU_MODE  input  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
REQ-008 SHALL have port BGP  input  8  palette register (used only with palette feature).
REQ-009 SHALL have port FB_ADDR  output  13  framebuffer byte address.
REQ-010 SHALL have port FB_WDATA  output  8  four packed 2-bit pixels.
REQ-011 SHALL have port FB_WE  output  1  write request.
REQ-012 SHALL have port FB_READY  input  1  memory accepts write when high with FB_WE.
REQ-013 SHALL have port FRAME_DONE  output  1  one-cycle pulse when a frame's last byte is written.
REQ-014 SHALL have port OVERFLOW  output  1  sticky: packed byte dropped because FIFO full.

Function
REQ-015 Pixel accepted only when PX_valid=1, PPU_MODE=DRAW, line counter <144, x counter <160; others discarded.
REQ-016 Packer places the first pixel of each group in bits[7:6], then [5:4], [3:2], [1:0]; the 4th pixel completes the byte.
REQ-017 Completed byte pushed into FIFO with address FB_BASE + line*40 + x/4 (13-bit, wraps modulo 2^13).
REQ-018 On PPU_MODE leaving DRAW with 1-3 pixels pending, the partial byte SHALL be zero-padded and pushed; x counter clears to 0, line counter increments (saturates at 144).
REQ-019 On PPU_MODE entering V_BLANK: line counter, x counter, packer clear; FIFO contents SHALL NOT be discarded.
REQ-020 Writer FSM states IDLE, WRITE; IDLE->WRITE when FIFO non-empty; in WRITE, FB_WE=1 with FB_ADDR/FB_WDATA stable until FB_READY=1; transfer pops FIFO; WRITE->IDLE if FIFO then empty, else stays WRITE with next entry presented the following cycle.
REQ-021 Latency: 4th accepted pixel at cycle N -> FB_WE high at N+2 earliest (push N+1, present N+2).
REQ-022 Push and pop in the same cycle SHALL be allowed at any occupancy including full.
REQ-023 Push when FIFO full and no pop: byte dropped, OVERFLOW set; cleared only by reset.
REQ-024 FRAME_DONE pulses in the cycle after the transfer of address FB_BASE+5759.
REQ-025 FB_WE SHALL never be asserted while the FIFO is empty.

Reset
REQ-026 Asynchronous rst SHALL force FB_WE=0, FB_ADDR=0, FB_WDATA=0, FRAME_DONE=0, OVERFLOW=0, FSM=IDLE, FIFO empty, counters 0 immediately, including mid-transfer.
REQ-027 After rst deasserts, pixels are ignored until first PPU_MODE entry into V_BLANK or SCAN with line 0 (frame aligned).

Configuration
REQ-028 Macro PPU_FB_PALETTE_EN: when defined, each accepted index i is replaced by BGP[2i+1:2i] before packing, BGP sampled at acceptance; when undefined, raw PX_OUT packed and BGP unused.

Structure
REQ-029 Shared package SHALL hold PPU mode enum, LCD_W=160, LCD_H=144, BYTES_PER_LINE=40, FB_BYTES=5760.
REQ-030 FIFO SHALL be a sub-module ppu_fb_fifo (data+address width 21, FIFO_DEPTH, full/empty flags).

Verification
REQ-031 Palette off, 4 valid pixels 3,2,1,0 on line 0, FB_READY=1 -> one write FB_ADDR=0, FB_WDATA=8'hE4.
REQ-032 DRAW ends after 6 pixels all 3 -> writes 8'hFF at addr 0 and 8'hF0 at addr 1.
REQ-033 FB_READY held 0 for 20 cycles during write -> FB_WE, FB_ADDR, FB_WDATA unchanged until accepted.
REQ-034 FB_READY=0, push 17 bytes (depth 16) -> OVERFLOW=1, 16 bytes later written in order, 17th lost.
REQ-035 Full 144x160 frame, FB_READY=1 -> 5760 writes, last addr 5759, FRAME_DONE single pulse.
REQ-036 PPU_FB_PALETTE_EN defined, BGP=8'h1B, pixels 0,1,2,3 -> FB_WDATA=8'hE4.

Source files
------------

// File: rtl/ppu_fb_writer_pkg.sv
// Shared types and constants for the PPU framebuffer writer: PPU modes, LCD geometry,
// writer FSM states and the packed FIFO entry layout.
package ppu_fb_writer_pkg;

  typedef enum logic [1:0] {
    MODE_H_BLANK = 2'd0,
    MODE_V_BLANK = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_DRAW    = 2'd3
  } ppu_mode_e;

  typedef enum logic {
    WR_IDLE,
    WR_WRITE
  } wr_state_e;

  localparam int LCD_W          = 160;
  localparam int LCD_H          = 144;
  localparam int BYTES_PER_LINE = 40;
  localparam int FB_BYTES       = 5760;
  localparam int FB_AW          = 13;
  localparam int FIFO_W         = 21;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [7:0]       data;
  } fb_entry_t;

  // Byte address of the group holding pixel x on a line; wraps modulo 2^13.
  function automatic logic [FB_AW-1:0] fb_byte_addr(input logic [FB_AW-1:0] base,
                                                    input logic [7:0] line,
                                                    input logic [7:0] x);
    return base + FB_AW'(line) * FB_AW'(BYTES_PER_LINE) + FB_AW'(x >> 2);
  endfunction

endpackage

// File: rtl/ppu_fb_fifo.sv
// Show-ahead FIFO of packed framebuffer writes; simultaneous push and pop are
// accepted at any occupancy, including full.
module ppu_fb_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             last
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign last     = (count_q == (AW+1)'(1));

endmodule

// File: rtl/ppu_fb_writer.sv
// Packs 2-bit PPU pixels four to a byte and streams them to framebuffer memory.
// Optional macro PPU_FB_PALETTE_EN maps each pixel through BGP before packing.
module ppu_fb_writer
  import ppu_fb_writer_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [12:0] FB_BASE    = 13'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PX_OUT,
  input  logic        PX_valid,
  input  logic [1:0]  PPU_MODE,
  input  logic [7:0]  BGP,
  output logic [12:0] FB_ADDR,
  output logic [7:0]  FB_WDATA,
  output logic        FB_WE,
  input  logic        FB_READY,
  output logic        FRAME_DONE,
  output logic        OVERFLOW
);

  ppu_mode_e mode, mode_prev_q, mode_prev_d;
  wr_state_e state_q, state_d;
  logic       aligned_q, aligned_d;
  logic [7:0] line_q, line_d;
  logic [7:0] x_q, x_d;
  logic [7:0] pack_q, pack_d;
  logic [1:0] pcnt_q, pcnt_d;
  logic       overflow_q, overflow_d;
  logic       frame_done_q, frame_done_d;

  logic       enter_vblank, enter_scan, leave_draw, accept;
  logic [1:0] px_color;
  logic [7:0] pack_with;
  logic       push, pop;
  fb_entry_t  push_entry, head;
  logic [FIFO_W-1:0] fifo_rd;
  logic       fifo_full, fifo_empty, fifo_last;

`ifdef PPU_FB_PALETTE_EN
  assign px_color = BGP[{PX_OUT, 1'b0} +: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^BGP;
  assign px_color   = PX_OUT;
`endif

  always_comb begin
    mode         = ppu_mode_e'(PPU_MODE);
    enter_vblank = (mode == MODE_V_BLANK) && (mode_prev_q != MODE_V_BLANK);
    enter_scan   = (mode == MODE_SCAN) && (mode_prev_q != MODE_SCAN);
    leave_draw   = (mode_prev_q == MODE_DRAW) && (mode != MODE_DRAW);
    accept       = aligned_q && PX_valid && (mode == MODE_DRAW) &&
                   (line_q < 8'(LCD_H)) && (x_q < 8'(LCD_W));

    mode_prev_d  = mode;
    aligned_d    = aligned_q;
    line_d       = line_q;
    x_d          = x_q;
    pack_d       = pack_q;
    pcnt_d       = pcnt_q;
    push         = 1'b0;
    pack_with    = pack_q;
    pack_with[{~pcnt_q, 1'b0} +: 2] = px_color;
    push_entry.addr = fb_byte_addr(FB_BASE, line_q, x_q);
    push_entry.data = pack_q;

    if (!aligned_q) begin
      if (enter_vblank || (enter_scan && line_q == 8'd0)) aligned_d = 1'b1;
    end else begin
      if (accept) begin
        x_d    = x_q + 8'd1;
        pcnt_d = pcnt_q + 2'd1;
        if (pcnt_q == 2'd3) begin
          push            = 1'b1;
          push_entry.data = pack_with;
          pack_d          = 8'h00;
        end else begin
          pack_d = pack_with;
        end
      end
      // Partial group already sits left-aligned in pack_q with zero padding.
      if (leave_draw) begin
        push   = (pcnt_q != 2'd0);
        pack_d = 8'h00;
        pcnt_d = 2'd0;
        x_d    = 8'd0;
        if (line_q < 8'(LCD_H)) line_d = line_q + 8'd1;
      end
      if (enter_vblank) begin
        line_d = 8'd0;
        x_d    = 8'd0;
        pack_d = 8'h00;
        pcnt_d = 2'd0;
      end
    end
  end

  ppu_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .last      (fifo_last)
  );

  always_comb begin
    head         = fifo_rd;
    pop          = (state_q == WR_WRITE) && FB_READY;
    state_d      = state_q;
    overflow_d   = overflow_q | (push && fifo_full && !pop);
    frame_done_d = pop && (head.addr == FB_BASE + 13'(FB_BYTES - 1));
    case (state_q)
      WR_IDLE:  if (!fifo_empty) state_d = WR_WRITE;
      // Leave only when this pop drains the FIFO and nothing arrives alongside it.
      WR_WRITE: if (pop && fifo_last && !push) state_d = WR_IDLE;
      default:  state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WR_IDLE;
      mode_prev_q  <= MODE_H_BLANK;
      aligned_q    <= 1'b0;
      line_q       <= 8'd0;
      x_q          <= 8'd0;
      pack_q       <= 8'h00;
      pcnt_q       <= 2'd0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_prev_q  <= mode_prev_d;
      aligned_q    <= aligned_d;
      line_q       <= line_d;
      x_q          <= x_d;
      pack_q       <= pack_d;
      pcnt_q       <= pcnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign FB_WE      = (state_q == WR_WRITE);
  assign FB_ADDR    = FB_WE ? head.addr : 13'h0000;
  assign FB_WDATA   = FB_WE ? head.data : 8'h00;
  assign FRAME_DONE = frame_done_q;
  assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed self-checking bench for ppu_fb_writer (default depth 16, base 0).
module tb_ppu_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PX_OUT;
  logic        PX_valid;
  logic [1:0]  PPU_MODE;
  logic [7:0]  BGP;
  logic [12:0] FB_ADDR;
  logic [7:0]  FB_WDATA;
  logic        FB_WE;
  logic        FB_READY;
  logic        FRAME_DONE;
  logic        OVERFLOW;

  int n_checks = 0;
  int n_fails  = 0;

  logic [12:0] aq[$];
  logic [7:0]  dq[$];
  int fd_count = 0;
  int fd_at    = -1;

  ppu_fb_writer dut (
    .clk        (clk),
    .rst        (rst),
    .PX_OUT     (PX_OUT),
    .PX_valid   (PX_valid),
    .PPU_MODE   (PPU_MODE),
    .BGP        (BGP),
    .FB_ADDR    (FB_ADDR),
    .FB_WDATA   (FB_WDATA),
    .FB_WE      (FB_WE),
    .FB_READY   (FB_READY),
    .FRAME_DONE (FRAME_DONE),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 clk = ~clk;

  // Record every accepted transfer and every FRAME_DONE pulse.
  always @(negedge clk) begin
    if (!rst && FB_WE && FB_READY) begin
      aq.push_back(FB_ADDR);
      dq.push_back(FB_WDATA);
      $display("write addr=%0d data=%02h", FB_ADDR, FB_WDATA);
    end
    if (!rst && FRAME_DONE) begin
      fd_count++;
      fd_at = aq.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic draw_px(input logic [1:0] v);
    PPU_MODE = 2'd3;
    PX_valid = 1'b1;
    PX_OUT   = v;
    tick();
    PX_valid = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    PPU_MODE = m;
    tick();
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int c = 0;
    while (aq.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, aq.size(), n);
  endtask

  task automatic clear_log();
    aq.delete();
    dq.delete();
  endtask

  initial begin
    logic [7:0] kb;
    logic [7:0] lb;
    int bad;

    rst = 1'b1; PX_OUT = 2'd0; PX_valid = 1'b0; PPU_MODE = 2'd0;
    BGP = 8'hE4; FB_READY = 1'b1;
    repeat (3) tick();
    chk("reset_we", FB_WE, 0);
    chk("reset_addr", FB_ADDR, 0);
    chk("reset_wdata", FB_WDATA, 0);
    chk("reset_frame_done", FRAME_DONE, 0);
    chk("reset_overflow", OVERFLOW, 0);
    rst = 1'b0;
    tick();

    // Before any V_BLANK/SCAN entry, pixels are ignored.
    repeat (4) draw_px(2'd3);
    set_mode(2'd0);
    repeat (5) tick();
    chk("unaligned_ignored", aq.size(), 0);

    // One packed byte, latency from 4th pixel to FB_WE.
    set_mode(2'd1);
`ifdef PPU_FB_PALETTE_EN
    BGP = 8'h1B;
    draw_px(2'd0); draw_px(2'd1); draw_px(2'd2); draw_px(2'd3);
    BGP = 8'hE4;
`else
    draw_px(2'd3); draw_px(2'd2); draw_px(2'd1); draw_px(2'd0);
`endif
    chk("lat_we_n1", FB_WE, 0);
    tick();
    chk("lat_we_n2", FB_WE, 1);
    chk("lat_addr", FB_ADDR, 0);
    chk("lat_wdata", FB_WDATA, 8'hE4);
    set_mode(2'd0);
    wait_writes(1, 20, "single_count");
    chk("single_addr", aq[0], 0);
    chk("single_data", dq[0], 8'hE4);

    // Partial byte flush on leaving DRAW, then line 1 addressing.
    clear_log();
    set_mode(2'd1);
    repeat (6) draw_px(2'd3);
    set_mode(2'd0);
    repeat (4) draw_px(2'd1);
    set_mode(2'd0);
    wait_writes(3, 30, "flush_count");
    chk("flush_addr0", aq[0], 0);
    chk("flush_data0", dq[0], 8'hFF);
    chk("flush_addr1", aq[1], 1);
    chk("flush_data1", dq[1], 8'hF0);
    chk("line1_addr", aq[2], 40);
    chk("line1_data", dq[2], 8'h55);

    // Back-pressure: request must hold steady while FB_READY is low.
    clear_log();
    FB_READY = 1'b0;
    repeat (4) draw_px(2'd2);
    set_mode(2'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("stall_we", FB_WE, 1);
      chk("stall_addr", FB_ADDR, 80);
      chk("stall_wdata", FB_WDATA, 8'hAA);
      tick();
    end
    chk("stall_no_write", aq.size(), 0);
    FB_READY = 1'b1;
    wait_writes(1, 10, "stall_count");
    chk("stall_done_addr", aq[0], 80);

    // Overflow: 17 bytes into a 16-deep FIFO with the memory stalled.
    clear_log();
    FB_READY = 1'b0;
    set_mode(2'd1);
    for (int k = 0; k < 16; k++) begin
      kb = 8'(k);
      draw_px(kb[7:6]); draw_px(kb[5:4]); draw_px(kb[3:2]); draw_px(kb[1:0]);
    end
    chk("ovf_before", OVERFLOW, 0);
    kb = 8'd16;
    draw_px(kb[7:6]); draw_px(kb[5:4]); draw_px(kb[3:2]); draw_px(kb[1:0]);
    chk("ovf_set", OVERFLOW, 1);
    set_mode(2'd0);
    FB_READY = 1'b1;
    wait_writes(16, 100, "ovf_count");
    repeat (5) tick();
    chk("ovf_no_17th", aq.size(), 16);
    for (int k = 0; k < 16; k++) begin
      chk("ovf_addr", aq[k], k);
      chk("ovf_data", dq[k], k);
    end
    chk("ovf_sticky", OVERFLOW, 1);

    // Asynchronous reset in the middle of a stalled transfer.
    FB_READY = 1'b0;
    set_mode(2'd1);
    repeat (4) draw_px(2'd3);
    set_mode(2'd0);
    chk("pre_rst_we", FB_WE, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", FB_WE, 0);
    chk("arst_addr", FB_ADDR, 0);
    chk("arst_wdata", FB_WDATA, 0);
    chk("arst_overflow", OVERFLOW, 0);
    FB_READY = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle", FB_WE, 0);

    // Full frame.
    clear_log();
    fd_count = 0;
    set_mode(2'd1);
    for (int l = 0; l < 144; l++) begin
      lb = 8'(l);
      for (int x = 0; x < 160; x++) draw_px(lb[1:0]);
      set_mode(2'd0);
    end
    wait_writes(5760, 200, "frame_count");
    repeat (5) tick();
    chk("frame_last_addr", aq[aq.size()-1], 5759);
    bad = 0;
    for (int i = 0; i < aq.size(); i++) begin
      lb = 8'(i / 40);
      if (aq[i] !== 13'(i) || dq[i] !== {4{lb[1:0]}}) bad++;
    end
    chk("frame_contents", bad, 0);
    chk("frame_done_pulses", fd_count, 1);
    chk("frame_done_timing", fd_at, 5760);

    // Line counter saturated at 144: further pixels discarded.
    repeat (4) draw_px(2'd3);
    set_mode(2'd0);
    repeat (10) tick();
    chk("line_saturate", aq.size(), 5760);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
